key_debounce: RTL and testbench

KEY_DEBOUNCE -- requirements
Module: key_debounce

---
 rtl/key_debounce.sv | 120 ++++++++++++
 tb/tb_key_debounce.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/key_debounce.sv
// Multi-key debouncer: a 2-flop synchronizer and a 4-state press/release FSM per key.
// Emits the debounced level, one-cycle press/release pulses and an OR'd press enable.
module key_debounce #(
    parameter int NKEYS     = 4,
    parameter int DB_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NKEYS-1:0] key,
    output logic [NKEYS-1:0] key_db,
    output logic [NKEYS-1:0] key_press,
    output logic [NKEYS-1:0] key_release,
    output logic             en
);

    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_WAIT = 2'd1,
        HELD       = 2'd2,
        REL_WAIT   = 2'd3
    } state_e;

    logic [NKEYS-1:0] s1_q;
    logic [NKEYS-1:0] s2_q;
    logic [NKEYS-1:0] press_d;
    logic             en_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= key;
            s2_q <= s1_q;
        end
    end

    for (genvar i = 0; i < NKEYS; i++) begin : g_key
        state_e          state_q;
        logic [CW-1:0]   cnt_q;
        logic            db_q;
        logic            press_q;
        logic            rel_q;

        // Press accepted this edge; also feeds the shared enable flop.
        assign press_d[i] = (state_q == PRESS_WAIT) && s2_q[i]
                            && (cnt_q == LAST);

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                db_q    <= 1'b0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
            end else begin
                press_q <= 1'b0;
                rel_q   <= 1'b0;
                unique case (state_q)
                    IDLE: begin
                        if (s2_q[i]) begin
                            state_q <= PRESS_WAIT;
                            cnt_q   <= '0;
                        end
                    end
                    PRESS_WAIT: begin
                        if (!s2_q[i]) begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                        end else if (cnt_q == LAST) begin
                            state_q <= HELD;
                            cnt_q   <= '0;
                            db_q    <= 1'b1;
                            press_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    HELD: begin
                        if (!s2_q[i]) begin
                            state_q <= REL_WAIT;
                            cnt_q   <= '0;
                        end
                    end
                    REL_WAIT: begin
                        if (s2_q[i]) begin
                            state_q <= HELD;
                            cnt_q   <= '0;
                        end else if (cnt_q == LAST) begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                            db_q    <= 1'b0;
                            rel_q   <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                endcase
            end
        end

        assign key_db[i]      = db_q;
        assign key_press[i]   = press_q;
        assign key_release[i] = rel_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_q <= 1'b0;
        end else begin
            en_q <= |press_d;
        end
    end

    assign en = en_q;

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce (NKEYS=4, DB_CYCLES=4).
// Stimulus pushes expected output events; a negedge monitor pops and compares.
module tb_key_debounce;

    localparam int NK  = 4;
    localparam int N   = 4;
    localparam int LAT = N + 3;

    typedef struct {
        int           cyc;
        logic [NK-1:0] press;
        logic [NK-1:0] rel;
        logic [NK-1:0] db;
        logic          en;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [NK-1:0] key;
    logic [NK-1:0] key_db;
    logic [NK-1:0] key_press;
    logic [NK-1:0] key_release;
    logic          en;

    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    key_debounce #(.NKEYS(NK), .DB_CYCLES(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .key         (key),
        .key_db      (key_db),
        .key_press   (key_press),
        .key_release (key_release),
        .en          (en)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every cycle with a pulse or enable must match the queue head.
    always @(negedge clk) begin
        if (|key_press || |key_release || en) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event cyc=%0d press=%b rel=%b db=%b en=%b",
                         cyc, key_press, key_release, key_db, en);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (e.cyc != cyc || e.press !== key_press ||
                    e.rel !== key_release || e.db !== key_db ||
                    e.en !== en) begin
                    errors++;
                    $display("FAIL event got cyc=%0d p=%b r=%b db=%b en=%b want cyc=%0d p=%b r=%b db=%b en=%b",
                             cyc, key_press, key_release, key_db, en,
                             e.cyc, e.press, e.rel, e.db, e.en);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int at, input logic [NK-1:0] p,
                        input logic [NK-1:0] r, input logic [NK-1:0] d,
                        input logic e);
        exp_t x;
        x.cyc = at; x.press = p; x.rel = r; x.db = d; x.en = e;
        sb.push_back(x);
    endtask

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_db"}, 32'(key_db), 32'h0);
        check({name, "_press"}, 32'(key_press), 32'h0);
        check({name, "_rel"}, 32'(key_release), 32'h0);
        check({name, "_en"}, 32'(en), 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        key = '0;
        #2 rst = 1'b0;
        #1 check_all_zero("reset");
        step(3);
        rst = 1'b1;
        step(2);

        // Clean press and release of key 0
        key = 4'b0001;
        push(cyc + LAT, 4'b0001, 4'b0000, 4'b0001, 1'b1);
        step(64);
        check("clean_db_held", 32'(key_db), 32'h1);
        key = 4'b0000;
        push(cyc + LAT, 4'b0000, 4'b0001, 4'b0000, 1'b0);
        step(20);
        check("clean_db_rel", 32'(key_db), 32'h0);

        // Bounce on key 1: no events expected
        key = 4'b0010; step(1);
        key = 4'b0000; step(1);
        key = 4'b0010; step(1);
        key = 4'b0000; step(20);
        check("bounce_db", 32'(key_db), 32'h0);
        check("bounce_en", 32'(en), 32'h0);

        // Simultaneous press
        key = 4'b1111;
        push(cyc + LAT, 4'b1111, 4'b0000, 4'b1111, 1'b1);
        step(20);
        check("simul_db", 32'(key_db), 32'hF);

        // Release bounce on key 2 while held
        key = 4'b1011; step(2);
        key = 4'b1111; step(20);
        check("relbounce_db", 32'(key_db), 32'hF);

        key = 4'b0000;
        push(cyc + LAT, 4'b0000, 4'b1111, 4'b0000, 1'b0);
        step(20);
        check("all_rel_db", 32'(key_db), 32'h0);

        // Reset while PRESS_WAIT cnt=2, then release with key high
        key = 4'b0001;
        step(5);
        rst = 1'b0;
        #1 check_all_zero("midrst");
        step(4);
        check_all_zero("midrst_hold");
        rst = 1'b1;
        push(cyc + LAT, 4'b0001, 4'b0000, 4'b0001, 1'b1);
        step(20);
        check("postrst_db", 32'(key_db), 32'h1);
        key = 4'b0000;
        push(cyc + LAT, 4'b0000, 4'b0001, 4'b0000, 1'b0);
        step(20);

        // Long hold on key 3
        key = 4'b1000;
        push(cyc + LAT, 4'b1000, 4'b0000, 4'b1000, 1'b1);
        step(200);
        check("long_db", 32'(key_db), 32'h8);
        key = 4'b0000;
        push(cyc + LAT, 4'b0000, 4'b1000, 4'b0000, 1'b0);
        step(20);
        check("long_db_rel", 32'(key_db), 32'h0);

        check("sb_drained", 32'(sb.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
